// File: rtl/hazard_pkg.sv
// Shared types for the pipeline interlock: FSM states, stall-length type and the zero register.
package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [1:0] stall_len_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_muldiv_busy.sv
// Busy counter for the multi-cycle mul/div unit: loads MULDIV_LAT on an accepted start, counts down to 0.
module muldiv_busy #(
  parameter int MULDIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int W = $clog2(MULDIV_LAT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= W'(MULDIV_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush interlock beside the ID stage for the 5-stage MIPS core.
// Optional mul/div busy interlock is built when HAZARD_MULDIV_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_branch,
  input  logic        id_redirect,
  input  logic        id_muldiv_start,
  input  logic        id_reads_hilo,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_dst,
  input  logic        mem_memread,
  input  logic [4:0]  mem_dst,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [31:0] stall_count
);

  state_t     state, state_nxt;
  stall_len_t hold_cnt, hold_nxt;
  stall_len_t stall_len;
  logic       ex_hit, mem_hit;
  logic       muldiv_stall;
  logic       stall;

  // A producer matches when it writes a real register that the ID instruction actually reads.
  assign ex_hit  = (ex_dst != REG_ZERO) &&
                   ((id_uses_rs && (ex_dst == id_rs)) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_hit = (mem_dst != REG_ZERO) &&
                   ((id_uses_rs && (mem_dst == id_rs)) || (id_uses_rt && (mem_dst == id_rt)));

  // Branches resolve in ID, so they also wait on ALU results still in EX and loads in MEM.
  always_comb begin
    stall_len = 2'd0;
    if (id_is_branch) begin
      if (ex_memread && ex_hit) begin
        stall_len = 2'd2;
      end else if ((ex_regwrite && ex_hit) || (mem_memread && mem_hit)) begin
        stall_len = 2'd1;
      end
    end else if (ex_memread && ex_hit) begin
      stall_len = 2'd1;
    end
  end

`ifdef HAZARD_MULDIV_EN
  logic busy;
  logic muldiv_accept;

  assign muldiv_accept = id_muldiv_start && !stall;
  assign muldiv_stall  = busy && (id_reads_hilo || id_muldiv_start);

  muldiv_busy #(
    .MULDIV_LAT(MULDIV_LAT)
  ) u_muldiv_busy (
    .clk  (clk),
    .rst  (rst),
    .start(muldiv_accept),
    .busy (busy)
  );
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{id_muldiv_start, id_reads_hilo, (MULDIV_LAT > 0)};
  assign muldiv_stall  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      hold_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stall     = 1'b0;
    case (state)
      RUN: begin
        stall = (stall_len != 2'd0) || muldiv_stall;
        if (stall_len == 2'd2) begin
          state_nxt = HOLD;
          hold_nxt  = 2'd1;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (hold_cnt != 2'd0) begin
          hold_nxt = hold_cnt - 2'd1;
        end
        if (hold_cnt <= 2'd1) begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Redirect flush is suppressed while stalled; the branch stays in ID and redirects once released.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = id_redirect;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 32'd0;
    end else if (id_ex_bubble) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule
